// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central sequencer for the 5-stage RV64I pipeline. It turns load-use
//   hazards, EX-stage control-flow redirects and data-memory wait states into
//   PC and per-stage pipeline-register enable/flush controls. It also owns
//   reset flushing, memory-wait freezing with timeout detection, a sticky
//   error halt, and saturating stall/flush performance counters.
//
// Ports
//   clk, reset_n              clock, async active-low reset
//   id_rs1_idx/id_rs2_idx     source register indices of the ID instruction
//   id_uses_rs1/id_uses_rs2   ID instruction actually reads rs1/rs2
//   ex_mem_read, ex_rd_idx    EX instruction is a load / its destination
//   ex_redirect               EX resolved a taken branch / JAL / JALR
//   mem_req, dmem_ready       MEM-stage data access and its completion
//   pc_enable, pc_redirect    PC update / PC loads EX target
//   *_enable, *_flush         pipeline-register latch / bubble controls
//   mem_timeout_err           sticky data-memory timeout flag
//   stall_cnt, flush_cnt      saturating performance counters
//
// State      | meaning
// -----------+-------------------------------------------------------------
// RST_FLUSH  | first cycle out of reset, bubbles IF/ID and ID/EX
// RUN        | normal flow, hazard and redirect handling
// MEM_WAIT   | pipeline frozen on an outstanding data-memory access
// ERROR      | memory timeout, pipeline halted until reset

module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs1_idx,
  input  logic [4:0]       id_rs2_idx,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd_idx,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_enable,
  output logic             pc_redirect,
  output logic             if_id_enable,
  output logic             if_id_flush,
  output logic             id_ex_enable,
  output logic             id_ex_flush,
  output logic             ex_mem_enable,
  output logic             mem_wb_enable,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    RST_FLUSH = 2'd0,
    RUN       = 2'd1,
    MEM_WAIT  = 2'd2,
    ERROR     = 2'd3
  } state_t;

  state_t            state;
  // Remaining MEM_WAIT cycles before a still-pending access is a timeout.
  // The freezing RUN cycle is the first frozen cycle, so the count is
  // loaded with MEM_TIMEOUT-2 on entry and expires at zero.
  logic [WAIT_W-1:0] wait_left;

  logic freeze;
  logic load_use;
  logic release_ok;
  logic stall_inc;
  logic flush_inc;

  assign freeze = mem_req && !dmem_ready;

  // A load writing x0 produces nothing to forward, so it never stalls.
  assign load_use = ex_mem_read && (ex_rd_idx != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1_idx == ex_rd_idx)) ||
                     (id_uses_rs2 && (id_rs2_idx == ex_rd_idx)));

  // MEM_WAIT only watches dmem_ready: the access is already in flight.
  assign release_ok = (state == RUN)      ? !freeze :
                      (state == MEM_WAIT) ? dmem_ready : 1'b0;

  always_comb begin
    pc_enable     = 1'b0;
    pc_redirect   = 1'b0;
    if_id_enable  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_enable  = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_enable = 1'b0;
    mem_wb_enable = 1'b0;
    case (state)
      RST_FLUSH: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      RUN, MEM_WAIT: begin
        if (release_ok) begin
          // Redirect wins over load-use: the stalled ID instruction is
          // on the wrong path and gets squashed anyway.
          if (ex_redirect) begin
            pc_enable     = 1'b1;
            pc_redirect   = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_enable = 1'b1;
            mem_wb_enable = 1'b1;
          end else if (load_use) begin
            id_ex_flush   = 1'b1;
            ex_mem_enable = 1'b1;
            mem_wb_enable = 1'b1;
          end else begin
            pc_enable     = 1'b1;
            if_id_enable  = 1'b1;
            id_ex_enable  = 1'b1;
            ex_mem_enable = 1'b1;
            mem_wb_enable = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  assign stall_inc = ((state == RUN) || (state == MEM_WAIT)) && !pc_enable;
  assign flush_inc = pc_redirect;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= RST_FLUSH;
      wait_left       <= '0;
      stall_cnt       <= '0;
      flush_cnt       <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      case (state)
        RST_FLUSH: state <= RUN;
        RUN: begin
          if (freeze) begin
            state     <= MEM_WAIT;
            wait_left <= WAIT_W'(MEM_TIMEOUT - 2);
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state     <= RUN;
            wait_left <= '0;
          end else if (wait_left == '0) begin
            state           <= ERROR;
            mem_timeout_err <= 1'b1;
          end else begin
            wait_left <= wait_left - 1'b1;
          end
        end
        ERROR: state <= ERROR;
        default: state <= RST_FLUSH;
      endcase

      if (stall_inc && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the 5-stage RV64I pipeline.
- Generates PC and per-stage pipeline-register enable/flush controls (IF/ID, ID/EX, EX/MEM, MEM/WB) from three sources: load-use hazards, EX-stage control-flow redirects, and data-memory wait states.
- Owns a small FSM for reset flushing, memory-wait freezing with timeout detection, and a sticky error halt.
- Keeps saturating stall and flush performance counters.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before error (>=2)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock; all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
id_rs1_idx  in  5  rs1 index of instruction in ID
id_rs2_idx  in  5  rs2 index of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_mem_read  in  1  EX instruction is a load
ex_rd_idx  in  5  destination of EX instruction
ex_redirect  in  1  EX resolved taken branch / JAL / JALR
mem_req  in  1  MEM stage issuing a data-memory access
dmem_ready  in  1  data memory completes access this cycle
pc_enable  out  1  PC register update
pc_redirect  out  1  PC loads EX target instead of PC+4
if_id_enable  out  1  IF/ID latch
if_id_flush  out  1  IF/ID bubble
id_ex_enable  out  1  ID/EX latch
id_ex_flush  out  1  ID/EX bubble (control fields cleared)
ex_mem_enable  out  1  EX/MEM latch
mem_wb_enable  out  1  MEM/WB latch
mem_timeout_err  out  1  sticky timeout flag
stall_cnt  out  CNT_W  cycles with pc_enable=0 while in RUN/MEM_WAIT
flush_cnt  out  CNT_W  accepted redirects

Behaviour:
- States: RST_FLUSH, RUN, MEM_WAIT, ERROR. Outputs are combinational from state and inputs; counters, wait_cnt and the error flag are registered.
- While reset_n=0: state=RST_FLUSH, wait_cnt=0, stall_cnt=0, flush_cnt=0, mem_timeout_err=0.
- RST_FLUSH outputs: if_id_flush=1, id_ex_flush=1, pc_redirect=0, all enables and pc_enable=0. Next state is unconditionally RUN.
- freeze = mem_req && !dmem_ready.
- RUN, priority order:
  - (1) freeze: all enables and pc_enable=0, flushes=0, pc_redirect=0; next state MEM_WAIT; wait_cnt<=1.
  - (2) ex_redirect: pc_enable=1, pc_redirect=1, if_id_flush=1, id_ex_flush=1, ex_mem_enable=mem_wb_enable=1; flush_cnt++. Redirect overrides a simultaneous load-use hazard, because the ID instruction is squashed.
  - (3) load-use: ex_mem_read && ex_rd_idx!=0 && ((id_uses_rs1 && id_rs1_idx==ex_rd_idx) || (id_uses_rs2 && id_rs2_idx==ex_rd_idx)). Then pc_enable=0, if_id_enable=0, id_ex_flush=1, ex_mem_enable=mem_wb_enable=1. The stall lasts exactly one cycle, since the load then advances to MEM.
  - (4) else: all enables=1, pc_enable=1, flushes=0, pc_redirect=0.
- MEM_WAIT:
  - If dmem_ready=1: apply RUN rules (2)-(4) this same cycle (zero-cycle release); next state RUN; wait_cnt<=0.
  - If dmem_ready=0 and wait_cnt==MEM_TIMEOUT-1: next state ERROR; mem_timeout_err<=1.
  - Otherwise: frozen outputs as in (1); wait_cnt++.
- ex_redirect asserted during MEM_WAIT is not acted on. The EX stage is frozen, so the redirect is taken on the release cycle.
- ERROR: all enables and pc_enable=0, flushes=0. The state is held until reset_n=0. mem_timeout_err stays 1.
- Counters:
  - stall_cnt increments on each cycle in RUN or MEM_WAIT where pc_enable=0.
  - flush_cnt increments on each redirect acted on.
  - Both saturate at all-ones. Neither counts in RST_FLUSH or ERROR.
- ex_rd_idx==0 never causes a stall. A flush and an enable for the same register are never both 1.
- Asynchronous reset mid-MEM_WAIT or mid-ERROR returns to RST_FLUSH immediately and clears all counters and flags.

Test Plan:
- Reset release: reset_n low 3 cycles then high -> one cycle with if_id_flush=id_ex_flush=1 and pc_enable=0, then RUN with all enables=1; counters 0.
- Load-use: ex_mem_read=1, ex_rd_idx=5, id_uses_rs2=1, id_rs2_idx=5 -> exactly one cycle with pc_enable=0, if_id_enable=0, id_ex_flush=1; stall_cnt=1. Same stimulus with ex_rd_idx=0 -> no stall.
- Redirect plus load-use simultaneously -> pc_redirect=1, if_id_flush=id_ex_flush=1, pc_enable=1; flush_cnt=1, stall_cnt unchanged.
- Memory wait: mem_req=1, dmem_ready low for 4 cycles then high -> 4 frozen cycles, then release-cycle enables=1; stall_cnt=4. Redirect held during the wait is applied on the release cycle.
- Timeout with MEM_TIMEOUT=16: dmem_ready never asserts -> ERROR entered after 16 frozen cycles; mem_timeout_err=1 persists through 10 more cycles; reset_n pulse clears it.
- Saturation with CNT_W=4: 20 load-use stalls -> stall_cnt holds at 15.
